// File: rtl/score_pkg.sv
// Shared definitions for the score record keeper.
//   BCD_W      : bits per BCD digit
//   DEF_DIGITS : default number of digits in a score
//   state_t    : controller state encoding
package score_pkg;

  localparam int BCD_W      = 4;
  localparam int DEF_DIGITS = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    FLASH   = 2'd2
  } state_t;

endpackage

// File: rtl/score_record_keeper_blink_timer.sv
// Blink sequencer for the new-record display effect.
// A start pulse begins phase 0 (display lit). Each phase lasts BLINK_CYCLES clocks
// and the blank level toggles at every phase boundary. After 2*BLINK_COUNT phases
// the sequence ends with blank low.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-low
//   start  in   one-cycle pulse, restarts the sequence
//   blank  out  1 = display dark
//   done   out  high during the last cycle of the last phase
module blink_timer #(
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int BLINK_COUNT  = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic blank,
  output logic done
);

  localparam int CNT_W = $clog2(BLINK_CYCLES + 1);
  localparam int PH_W  = $clog2(2 * BLINK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLINK_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LOAD  = PH_W'(2 * BLINK_COUNT - 1);

  // Both counters run downwards; a phase ends when cnt reaches zero and the
  // sequence ends when that happens with no phases left.
  logic [CNT_W-1:0] cnt;
  logic [PH_W-1:0]  phase_left;
  logic             active;
  logic             wrap;

  assign wrap = active && (cnt == '0);
  assign done = wrap && (phase_left == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      phase_left <= '0;
      active     <= 1'b0;
      blank      <= 1'b0;
    end else if (start) begin
      cnt        <= CNT_LOAD;
      phase_left <= PH_LOAD;
      active     <= 1'b1;
      blank      <= 1'b0;
    end else if (done) begin
      active <= 1'b0;
      blank  <= 1'b0;
    end else if (wrap) begin
      cnt        <= CNT_LOAD;
      phase_left <= phase_left - PH_W'(1);
      blank      <= ~blank;
    end else if (active) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/score_record_keeper.sv
// Best-score keeper. On a rising edge of game_over the live score is frozen and
// compared with the stored best, most significant digit first, one digit per
// clock. A strictly higher score replaces the best and starts a blink sequence.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   IDLE    | waiting for game over; clear_best honoured here
//   COMPARE | walking digits MSD->LSD, snap vs best
//   FLASH   | new record stored, display blinking
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low, clears best as well
//   game_over  in   level, rising edge ends a game
//   clear_best in   zero the best score (IDLE only)
//   show_best  in   1: show best while IDLE, 0: show live score
//   score_bcd  in   live score, digit 0 in the low nibble
//   best_bcd   out  stored best score
//   disp_bcd   out  digits for the hex decoders (registered)
//   blank      out  1 = display dark
//   new_record out  one-cycle pulse when best_bcd is replaced
//   busy       out  1 whenever not IDLE
module score_record_keeper
  import score_pkg::*;
#(
  parameter int DIGITS       = DEF_DIGITS,
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int BLINK_COUNT  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      game_over,
  input  logic                      clear_best,
  input  logic                      show_best,
  input  logic [BCD_W*DIGITS-1:0]   score_bcd,
  output logic [BCD_W*DIGITS-1:0]   best_bcd,
  output logic [BCD_W*DIGITS-1:0]   disp_bcd,
  output logic                      blank,
  output logic                      new_record,
  output logic                      busy
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_MSD = IDX_W'(DIGITS - 1);

  state_t                    state, state_nx;
  logic                      go_q;
  logic                      go_edge;
  logic [BCD_W*DIGITS-1:0]   snap;
  logic [IDX_W-1:0]          idx;
  logic [BCD_W-1:0]          snap_dig;
  logic [BCD_W-1:0]          best_dig;
  logic                      start_blink;
  logic                      blink_done;

  assign go_edge  = game_over & ~go_q;
  assign snap_dig = snap[idx*BCD_W +: BCD_W];
  assign best_dig = best_bcd[idx*BCD_W +: BCD_W];

  always_comb begin
    state_nx    = state;
    start_blink = 1'b0;
    unique case (state)
      IDLE: begin
        if (go_edge) state_nx = COMPARE;
      end
      COMPARE: begin
        if (snap_dig > best_dig) begin
          state_nx    = FLASH;
          start_blink = 1'b1;
        end else if ((snap_dig < best_dig) || (idx == '0)) begin
          // lower score, or every digit equal: a tie is not a record
          state_nx = IDLE;
        end
      end
      FLASH: begin
        if (blink_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      go_q       <= 1'b0;
      snap       <= '0;
      idx        <= '0;
      best_bcd   <= '0;
      disp_bcd   <= '0;
      new_record <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      busy       <= (state_nx != IDLE);
      go_q       <= game_over;
      new_record <= 1'b0;

      case (state)
        IDLE: begin
          if (go_edge) begin
            snap <= score_bcd;
            idx  <= IDX_MSD;
          end else if (clear_best) begin
            best_bcd <= '0;
          end
        end
        COMPARE: begin
          if (start_blink) begin
            best_bcd   <= snap;
            new_record <= 1'b1;
          end else if ((snap_dig == best_dig) && (idx != '0)) begin
            idx <= idx - IDX_W'(1);
          end
        end
        default: ;
      endcase

      // The display freezes on the final score while it is being judged.
      if ((state == FLASH) || ((state == IDLE) && show_best))
        disp_bcd <= best_bcd;
      else if (state == COMPARE)
        disp_bcd <= snap;
      else
        disp_bcd <= score_bcd;
    end
  end

  blink_timer #(
    .BLINK_CYCLES (BLINK_CYCLES),
    .BLINK_COUNT  (BLINK_COUNT)
  ) u_blink (
    .clk   (clk),
    .reset (reset),
    .start (start_blink),
    .blank (blank),
    .done  (blink_done)
  );

endmodule
